vga_mem_reader: RTL

//  Display-side reader for the processor's data memory VGA port: drives addressForVga,

---
 rtl/vga_mem_reader_if.sv | 9 +
 rtl/vga_mem_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_reader_if.sv
// Read port between the VGA bitmap reader and the data memory.
// The reader presents a word address and samples the returned word.
interface vga_mem_reader_if;
   logic [7:0]  addressForVga;
   logic [31:0] rdataForVga;

   modport master (output addressForVga, input  rdataForVga);
   modport slave  (input  addressForVga, output rdataForVga);
endinterface

// File: rtl/vga_mem_reader.sv
// Renders one 16-word page of data memory as a 32x16 bit-cell bitmap on 640x480@60 VGA.
// One word is fetched per line during horizontal blanking; no dividers, cell position is counted.
module vga_mem_reader #(
   parameter int          CELL_W   = 16,
   parameter int          CELL_H   = 30,
   parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB   = 24'h000080,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       pageSel,
   vga_mem_reader_if.master mem,
   output logic             vga_clk,
   output logic             hsync,
   output logic             vsync,
   output logic             blank_n,
   output logic             sync_n,
   output logic [7:0]       vga_r,
   output logic [7:0]       vga_g,
   output logic [7:0]       vga_b
);

   typedef logic [9:0] cnt_t;

   localparam cnt_t H_LAST      = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_LAST      = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t H_ACT       = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT       = cnt_t'(V_ACTIVE);
   localparam cnt_t V_ACT_LAST  = cnt_t'(V_ACTIVE - 1);
   localparam cnt_t H_SYNC_S    = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_SYNC_E    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_SYNC_S    = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_SYNC_E    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam cnt_t DISP_W      = cnt_t'(32 * CELL_W);
   localparam cnt_t CELL_W_LAST = cnt_t'(CELL_W - 1);
   localparam cnt_t CELL_H_LAST = cnt_t'(CELL_H - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;

   logic        pix_en_q;
   cnt_t        hcount_q, hcount_d, vcount_q, vcount_d;
   cnt_t        hcell_q, hcell_d, vcell_q, vcell_d;
   logic [4:0]  hbit_q, hbit_d;
   logic [3:0]  vrow_q, vrow_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] line_q, line_d;
   logic [3:0]  page_q, page_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
   logic [23:0] rgb_q, rgb_d;

   logic        last_line, nv_valid, active;
   logic [3:0]  nrow;

   // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      hcell_d  = hcell_q;
      hbit_d   = hbit_q;
      vcell_d  = vcell_q;
      vrow_d   = vrow_q;
      if (pix_en_q) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            hcell_d  = '0;
            hbit_d   = '0;
            if (vcount_q == V_LAST) begin
               vcount_d = '0;
               vcell_d  = '0;
               vrow_d   = '0;
            end else begin
               vcount_d = vcount_q + 10'd1;
               if (vcell_q == CELL_H_LAST) begin
                  vcell_d = '0;
                  vrow_d  = vrow_q + 4'd1;
               end else begin
                  vcell_d = vcell_q + 10'd1;
               end
            end
         end else begin
            hcount_d = hcount_q + 10'd1;
            if (hcell_q == CELL_W_LAST) begin
               hcell_d = '0;
               hbit_d  = hbit_q + 5'd1;
            end else begin
               hcell_d = hcell_q + 10'd1;
            end
         end
      end
   end

   // Row of the line about to be displayed; the last blanking line prefetches row 0.
   assign last_line = (vcount_q == V_LAST);
   assign nv_valid  = last_line || (vcount_q < V_ACT_LAST);
   assign nrow      = last_line ? 4'd0 : ((vcell_q == CELL_H_LAST) ? vrow_q + 4'd1 : vrow_q);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      line_d  = line_q;
      page_d  = page_q;
      case (state_q)
         S_IDLE: begin
            if (pix_en_q && (hcount_q == H_ACT) && nv_valid) begin
               addr_d  = {page_q, nrow};
               state_d = S_ADDR;
            end
         end
         S_ADDR: state_d = S_CAPT;
         S_CAPT: begin
            line_d  = mem.rdataForVga;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Page only changes in vertical blanking so a frame never mixes two pages.
      if (pix_en_q && (vcount_q == V_ACT) && (hcount_q == '0)) page_d = pageSel;
   end

   assign active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

   always_comb begin
      hsync_d   = !((hcount_q >= H_SYNC_S) && (hcount_q < H_SYNC_E));
      vsync_d   = !((vcount_q >= V_SYNC_S) && (vcount_q < V_SYNC_E));
      blank_n_d = active;
      rgb_d     = '0;
      if (active && (hcount_q < DISP_W)) rgb_d = line_q[~hbit_q] ? FG_RGB : BG_RGB;
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_en_q  <= 1'b0;
         hcount_q  <= '0;
         vcount_q  <= '0;
         hcell_q   <= '0;
         hbit_q    <= '0;
         vcell_q   <= '0;
         vrow_q    <= '0;
         state_q   <= S_IDLE;
         addr_q    <= '0;
         line_q    <= '0;
         page_q    <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
      end else begin
         pix_en_q  <= ~pix_en_q;
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
         hcell_q   <= hcell_d;
         hbit_q    <= hbit_d;
         vcell_q   <= vcell_d;
         vrow_q    <= vrow_d;
         state_q   <= state_d;
         addr_q    <= addr_d;
         line_q    <= line_d;
         page_q    <= page_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         blank_n_q <= blank_n_d;
         rgb_q     <= rgb_d;
      end
   end

   assign mem.addressForVga = addr_q;
   assign vga_clk = pix_en_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign blank_n = blank_n_q;
   assign sync_n  = 1'b0;
   assign vga_r   = rgb_q[23:16];
   assign vga_g   = rgb_q[15:8];
   assign vga_b   = rgb_q[7:0];

endmodule
